// File: rtl/riscv_if_prefetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch stage.
// Holds the fetch FSM encoding, the queue entry layout and a PC alignment helper.
package riscv_if_prefetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/riscv_if_prefetch_if.sv
// I-cache read bus between the fetch stage (master) and the instruction cache (slave).
interface riscv_if_prefetch_if;

  logic        ICACHE_ren;
  logic        ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_wdata;
  logic        ICACHE_stall;
  logic [31:0] ICACHE_rdata;

  modport master (
    output ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata,
    input  ICACHE_stall, ICACHE_rdata
  );

  modport slave (
    input  ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata,
    output ICACHE_stall, ICACHE_rdata
  );

endinterface

// File: rtl/riscv_if_prefetch_sync_fifo.sv
// Synchronous FIFO with flush; head is the oldest entry, valid whenever empty is low.
module riscv_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/riscv_if_prefetch.sv
// Instruction-fetch stage streaming sequential I-cache reads into a prefetch queue.
// Redirects flush the queue; a redirect during an outstanding miss parks the target until the miss retires.
module riscv_if_prefetch
  import riscv_if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  riscv_if_prefetch_if.master      icache,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     inst_ready,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic [31:0]              PC
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  redirect_pc_al;

  logic         ren, fire, push, pop, flush;
  logic         q_empty, q_full_unused;
  logic [CW-1:0] q_count;
  fetch_entry_t q_din, q_head;

  // Request is a function of registered state only, so it holds steady through a stall.
  assign ren  = (state_q == DRAIN) | ((state_q == RUN) & (q_count != FULL_CNT));
  assign fire = ren & ~icache.ICACHE_stall;
  assign pop  = inst_valid & inst_ready & ~redirect;

  assign redirect_pc_al = word_align(redirect_pc);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (state_q == RUN) begin
      if (redirect) begin
        flush = 1'b1;
        if (!ren || fire) begin
          fetch_pc_d = redirect_pc_al;
        end else begin
          // Miss in flight: the cache must see the same address until it completes.
          target_d = redirect_pc_al;
          state_d  = DRAIN;
        end
      end else if (fire) begin
        push       = 1'b1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end else begin
      if (redirect) begin
        flush    = 1'b1;
        target_d = redirect_pc_al;
      end else if (fire) begin
        fetch_pc_d = target_q;
        state_d    = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
    target_q <= target_d;
  end

  assign q_din = '{pc: fetch_pc_q, inst: icache.ICACHE_rdata};

  riscv_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (q_din),
    .full  (q_full_unused),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  assign inst_valid = ~q_empty;
  assign inst       = q_empty ? 32'h0 : q_head.inst;
  assign inst_pc    = q_empty ? 32'h0 : q_head.pc;
  assign PC         = fetch_pc_q;

  assign icache.ICACHE_ren   = ren;
  assign icache.ICACHE_wen   = 1'b0;
  assign icache.ICACHE_addr  = fetch_pc_q[31:2];
  assign icache.ICACHE_wdata = 32'h0;

endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Directed bench for riscv_if_prefetch: hit stream, backpressure, redirects, miss handling, wrap and reset.
module tb_riscv_if_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect, inst_ready;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, pc_out;

  logic        rst_w_n, stall_w, redirect_w, ready_w;
  logic [31:0] redirect_pc_w;
  logic        valid_w;
  logic [31:0] inst_w, inst_pc_w, pc_w;

  int checks = 0;
  int errors = 0;

  riscv_if_prefetch_if bus ();
  riscv_if_prefetch_if bus_w ();

  // Cache model: a completing read returns the bitwise inverse of the byte address.
  assign bus.ICACHE_stall   = stall;
  assign bus.ICACHE_rdata   = (bus.ICACHE_ren && !bus.ICACHE_stall) ? ~{bus.ICACHE_addr, 2'b00} : 32'hDEAD_BEEF;
  assign bus_w.ICACHE_stall = stall_w;
  assign bus_w.ICACHE_rdata = (bus_w.ICACHE_ren && !bus_w.ICACHE_stall) ? ~{bus_w.ICACHE_addr, 2'b00} : 32'hDEAD_BEEF;

  riscv_if_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .icache      (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_ready  (inst_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .PC          (pc_out)
  );

  riscv_if_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk         (clk),
    .rst_n       (rst_w_n),
    .icache      (bus_w),
    .redirect    (redirect_w),
    .redirect_pc (redirect_pc_w),
    .inst_ready  (ready_w),
    .inst_valid  (valid_w),
    .inst        (inst_w),
    .inst_pc     (inst_pc_w),
    .PC          (pc_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    rst_w_n = 1'b0; stall_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 32'h0; ready_w = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_ren", {31'b0, bus.ICACHE_ren}, 32'd1);
    chk("rst_wen", {31'b0, bus.ICACHE_wen}, 32'd0);
    chk("rst_wdata", bus.ICACHE_wdata, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_addr", {2'b0, bus.ICACHE_addr}, 32'h0);
    rst_n = 1'b1;

    // Hit stream
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hit_pc", inst_pc, 32'(4 * i));
      chk("hit_inst", inst, ~32'(4 * i));
      chk("hit_valid", {31'b0, inst_valid}, 32'd1);
      chk("hit_addr", {2'b0, bus.ICACHE_addr}, 32'(i + 1));
    end

    // Empty the queue under a stall, then backpressure
    stall = 1'b1;
    tick();
    chk("prep_empty", {31'b0, inst_valid}, 32'd0);
    chk("prep_addr", {2'b0, bus.ICACHE_addr}, 32'd4);
    stall = 1'b0;
    inst_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("bp_ren", {31'b0, bus.ICACHE_ren}, (k < 4) ? 32'd1 : 32'd0);
    end
    chk("bp_head", inst_pc, 32'd16);
    chk("bp_pc", pc_out, 32'd32);
    inst_ready = 1'b1;
    tick();
    chk("bp_ren_back", {31'b0, bus.ICACHE_ren}, 32'd1);
    chk("bp_drain0", inst_pc, 32'd20);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("bp_drain_pc", inst_pc, 32'(20 + 4 * j));
      chk("bp_drain_inst", inst, ~32'(20 + 4 * j));
    end

    // Redirect on hit with three entries queued, coinciding with pop and fire
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("rdh_valid", {31'b0, inst_valid}, 32'd0);
    chk("rdh_addr", {2'b0, bus.ICACHE_addr}, 32'h40);
    chk("rdh_pc", pc_out, 32'h100);
    chk("rdh_inst", inst, 32'h0);
    tick();
    chk("rdh_first_pc", inst_pc, 32'h100);
    chk("rdh_first_inst", inst, ~32'h100);

    // Redirect during a miss at word address 8
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    chk("miss_setup_addr", {2'b0, bus.ICACHE_addr}, 32'd8);
    stall = 1'b1;
    tick();
    chk("miss_c1_addr", {2'b0, bus.ICACHE_addr}, 32'd8);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("miss_c2_addr", {2'b0, bus.ICACHE_addr}, 32'd8);
    chk("miss_c2_ren", {31'b0, bus.ICACHE_ren}, 32'd1);
    chk("miss_c2_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("miss_c3_addr", {2'b0, bus.ICACHE_addr}, 32'd8);
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    chk("miss_c4_addr", {2'b0, bus.ICACHE_addr}, 32'd8);
    tick();
    chk("miss_c5_addr", {2'b0, bus.ICACHE_addr}, 32'd8);
    chk("miss_c5_valid", {31'b0, inst_valid}, 32'd0);
    stall = 1'b0;
    tick();
    chk("miss_drop_valid", {31'b0, inst_valid}, 32'd0);
    chk("miss_next_addr", {2'b0, bus.ICACHE_addr}, 32'hC0);
    chk("miss_next_pc", pc_out, 32'h300);
    tick();
    chk("miss_first_pc", inst_pc, 32'h300);
    chk("miss_first_inst", inst, ~32'h300);

    // Simultaneous redirect, pop and fire; unaligned target
    redirect = 1'b1; redirect_pc = 32'h403;
    tick();
    redirect = 1'b0;
    chk("sim_valid", {31'b0, inst_valid}, 32'd0);
    chk("sim_pc", pc_out, 32'h400);
    chk("sim_addr", {2'b0, bus.ICACHE_addr}, 32'h100);
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("full_ren", {31'b0, bus.ICACHE_ren}, 32'd0);
    chk("full_head", inst_pc, 32'h400);
    chk("full_pc", pc_out, 32'h410);
    redirect = 1'b1; redirect_pc = 32'h500; inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("full_rd_valid", {31'b0, inst_valid}, 32'd0);
    chk("full_rd_pc", pc_out, 32'h500);
    chk("full_rd_ren", {31'b0, bus.ICACHE_ren}, 32'd1);

    // Wrap at 2^32, then reset mid-miss
    rst_w_n = 1'b1;
    tick();
    chk("wrap_0", inst_pc_w, 32'hFFFF_FFF8);
    tick();
    chk("wrap_1", inst_pc_w, 32'hFFFF_FFFC);
    tick();
    chk("wrap_2", inst_pc_w, 32'h0000_0000);
    tick();
    chk("wrap_3", inst_pc_w, 32'h0000_0004);
    chk("wrap_inst", inst_w, ~32'h0000_0004);
    stall_w = 1'b1;
    tick();
    chk("wmiss_addr", {2'b0, bus_w.ICACHE_addr}, 32'd2);
    chk("wmiss_ren", {31'b0, bus_w.ICACHE_ren}, 32'd1);
    rst_w_n = 1'b0;
    tick();
    rst_w_n = 1'b1;
    chk("wrst_valid", {31'b0, valid_w}, 32'd0);
    chk("wrst_inst", inst_w, 32'h0);
    chk("wrst_inst_pc", inst_pc_w, 32'h0);
    chk("wrst_ren", {31'b0, bus_w.ICACHE_ren}, 32'd1);
    chk("wrst_wen", {31'b0, bus_w.ICACHE_wen}, 32'd0);
    chk("wrst_wdata", bus_w.ICACHE_wdata, 32'h0);
    chk("wrst_pc", pc_w, 32'hFFFF_FFF8);
    chk("wrst_addr", {2'b0, bus_w.ICACHE_addr}, 32'h3FFF_FFFE);
    stall_w = 1'b0;
    tick();
    chk("wrst_first_pc", inst_pc_w, 32'hFFFF_FFF8);
    chk("wrst_first_valid", {31'b0, valid_w}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
